// File: rtl/fifo_relay_station_pkg.sv
// Shared helpers for the pipelined FIFO relay station: the credit threshold
// and the legality rule for the LEVEL/DEPTH pairing.
package fifo_relay_station_pkg;

   // Occupancy below which the producer is granted more credit. The buffer
   // keeps 2*LEVEL spare slots: up to LEVEL words can already be in the
   // forward chain, and up to LEVEL more can be fired before a stale
   // full flag is corrected by the backward chain.
   function automatic int relay_thresh(input int depth, input int level);
      return depth - 2 * level;
   endfunction

   // A relay needs at least one stage each way. It also needs room for the
   // full round trip plus two words, so the threshold stays at two or more.
   function automatic bit relay_params_ok(input int depth, input int level);
      return (level >= 1) && (depth >= 2 * level + 2);
   endfunction

endpackage

// File: rtl/fifo_relay_station_buffer.sv
// Circular first-word-fall-through buffer at the consumer end of the relay.
// It tracks occupancy and exports a raw credit flag. The top level pipelines
// that flag back to the producer.
module relay_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int THRESH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop_req,
   output logic                  empty_n,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  raw_full_n
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] THRESH_OCC = OCC_W'(THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [OCC_W-1:0]      occ;
   logic                  pop;

   // A pop only counts when there is a word to hand out. Reads while empty are ignored.
   assign pop = pop_req & (occ != '0);

   // Storage is left unreset. Only the pointers and occupancy define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping. The pointers wrap explicitly because DEPTH need not be a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         assert (!(push && (occ == OCC_FULL)));
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            occ <= occ + 1'b1;
         end else if (pop && !push) begin
            occ <= occ - 1'b1;
         end
      end
   end

   assign empty_n    = (occ != '0);
   assign dout       = mem[rd_ptr];
   assign raw_full_n = (occ < THRESH_OCC);

endmodule

// File: rtl/fifo_relay_station.sv
// Pipelined relay for long inter-PE stream links. Write valid/data travel
// forward through LEVEL register stages. The buffer's credit flag travels
// back through LEVEL stages. The relay_buffer at the far end absorbs the
// round-trip latency, so the producer never overruns it.
module fifo_relay_station
   import fifo_relay_station_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEVEL      = 2,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout
);

   localparam int THRESH = relay_thresh(DEPTH, LEVEL);

   if (!relay_params_ok(DEPTH, LEVEL)) begin : g_bad_params
      $error("fifo_relay_station: LEVEL must be >= 1 and DEPTH >= 2*LEVEL+2");
   end

   logic                                write_fire;
   logic                                raw_full_n;
   logic [LEVEL:0]                      fwd_valid_tap;
   logic [LEVEL:0][DATA_WIDTH-1:0]      fwd_data_tap;
   logic [LEVEL:0]                      bwd_full_n_tap;

   // Writes seen while the (delayed) credit flag is low are dropped here, so producer misuse cannot reach the buffer.
   assign write_fire       = if_write & if_write_ce & if_full_n;
   assign fwd_valid_tap[0] = write_fire;
   assign fwd_data_tap[0]  = if_din;
   assign bwd_full_n_tap[0] = raw_full_n;

   for (genvar i = 0; i < LEVEL; i++) begin : g_stage
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  full_n_q;

      // Forward valid bit. Clearing it on reset drops every word still in flight.
      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= fwd_valid_tap[i];
         end
      end

      // Forward payload. It needs no reset because the matching valid bit qualifies it.
      always_ff @(posedge clk) begin
         data_q <= fwd_data_tap[i];
      end

      // Backward credit. It resets to "not full" because the buffer is empty after reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            full_n_q <= 1'b1;
         end else begin
            full_n_q <= bwd_full_n_tap[i];
         end
      end

      assign fwd_valid_tap[i+1]  = valid_q;
      assign fwd_data_tap[i+1]   = data_q;
      assign bwd_full_n_tap[i+1] = full_n_q;
   end

   assign if_full_n = bwd_full_n_tap[LEVEL];

   relay_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .THRESH     (THRESH)
   ) u_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (fwd_valid_tap[LEVEL]),
      .push_data  (fwd_data_tap[LEVEL]),
      .pop_req    (if_read & if_read_ce),
      .empty_n    (if_empty_n),
      .dout       (if_dout),
      .raw_full_n (raw_full_n)
   );

endmodule

// File: tb/tb_fifo_relay_station.sv
// Directed bench for fifo_relay_station with LEVEL=2, DEPTH=8. The sequence
// covers reset, single-word latency, fill to credit limit, dropped writes,
// read enables, back-to-back throughput and reset mid-transfer, and ends
// with a scoreboarded random stream.
module tb_fifo_relay_station;

   localparam int DW = 32;
   localparam int LV = 2;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_full_n;
   logic          if_write_ce;
   logic          if_write;
   logic [DW-1:0] if_din;
   logic          if_empty_n;
   logic          if_read_ce;
   logic          if_read;
   logic [DW-1:0] if_dout;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb[$];

   fifo_relay_station #(
      .DATA_WIDTH (DW),
      .LEVEL      (LV),
      .DEPTH      (DP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_full_n   (if_full_n),
      .if_write_ce (if_write_ce),
      .if_write    (if_write),
      .if_din      (if_din),
      .if_empty_n  (if_empty_n),
      .if_read_ce  (if_read_ce),
      .if_read     (if_read),
      .if_dout     (if_dout)
   );

   // Free-running clock with a period of 10 time units.
   always #5 clk = ~clk;

   // Advance one cycle. Outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all producer and consumer inputs for the current cycle.
   task automatic applyStimulus(input logic wr, input logic wce, input logic [DW-1:0] din,
                                input logic rd, input logic rce);
      if_write    = wr;
      if_write_ce = wce;
      if_din      = din;
      if_read     = rd;
      if_read_ce  = rce;
   endtask

   // Compare an observed value with a bench-computed expectation.
   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Directed sequence, followed by the random scoreboard phase.
   initial begin
      logic          wr, wce, rd, rce;
      logic [DW-1:0] din;
      int            sent;
      int            budget;

      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      checkOutput("reset_full_n", {31'b0, if_full_n}, 32'd1);
      checkOutput("reset_empty_n", {31'b0, if_empty_n}, 32'd0);
      tick();
      reset = 1'b0;

      // Read pulses while empty must change nothing.
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
         tick();
         checkOutput("idle_read_empty_n", {31'b0, if_empty_n}, 32'd0);
         checkOutput("idle_read_full_n", {31'b0, if_full_n}, 32'd1);
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();

      // Single word: fired at t, visible at t+3, popped at t+3, gone at t+4.
      applyStimulus(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_t1_empty_n", {31'b0, if_empty_n}, 32'd0);
      tick();
      checkOutput("single_t2_empty_n", {31'b0, if_empty_n}, 32'd0);
      tick();
      checkOutput("single_t3_empty_n", {31'b0, if_empty_n}, 32'd1);
      checkOutput("single_t3_dout", if_dout, 32'hA5);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      tick();
      checkOutput("single_t4_empty_n", {31'b0, if_empty_n}, 32'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();

      // Fill: write every cycle. Credit drops at offset 8, so only offsets 0-7 fire and the rest are dropped.
      for (int i = 0; i < 12; i++) begin
         if (i == 7) checkOutput("fill_full_n_c7", {31'b0, if_full_n}, 32'd1);
         if (i == 8) checkOutput("fill_full_n_c8", {31'b0, if_full_n}, 32'd0);
         if (i == 11) checkOutput("fill_full_n_c11", {31'b0, if_full_n}, 32'd0);
         applyStimulus(1'b1, 1'b1, (i < 8) ? 32'h100 + i : 32'hBAD0 + i, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      for (int k = 0; k < 8; k++) begin
         checkOutput("drain_empty_n", {31'b0, if_empty_n}, 32'd1);
         checkOutput("drain_dout", if_dout, 32'h100 + k);
         applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
         tick();
      end
      checkOutput("drain_done_empty_n", {31'b0, if_empty_n}, 32'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < LV + 1; i++) tick();
      checkOutput("drain_full_n", {31'b0, if_full_n}, 32'd1);

      // A write with the write clock-enable low must never land.
      applyStimulus(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("wce_low_empty_n", {31'b0, if_empty_n}, 32'd0);

      // A read with the read clock-enable low must not pop.
      applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rce_word_dout", if_dout, 32'h55);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("rce_low_empty_n", {31'b0, if_empty_n}, 32'd1);
      checkOutput("rce_low_dout", if_dout, 32'h55);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      tick();
      checkOutput("rce_pop_empty_n", {31'b0, if_empty_n}, 32'd0);

      // Throughput: four back-to-back writes with a read every cycle give one word per cycle at offsets 3-6.
      for (int o = 0; o < 8; o++) begin
         if (o >= 3 && o <= 6) begin
            checkOutput("tput_empty_n", {31'b0, if_empty_n}, 32'd1);
            checkOutput("tput_dout", if_dout, 32'hC0 + o - 3);
         end
         if (o == 7) checkOutput("tput_done_empty_n", {31'b0, if_empty_n}, 32'd0);
         applyStimulus(o < 4, 1'b1, 32'hC0 + o, 1'b1, 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();

      // Reset mid-transfer: 7 writes, so 5 are stored and 2 are in flight at offset 7.
      for (int o = 0; o < 7; o++) begin
         applyStimulus(1'b1, 1'b1, 32'hE0 + o, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("prerst_dout", if_dout, 32'hE0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midrst_empty_n", {31'b0, if_empty_n}, 32'd0);
      checkOutput("midrst_full_n", {31'b0, if_full_n}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("postrst_empty_n", {31'b0, if_empty_n}, 32'd0);
      end
      checkOutput("postrst_full_n", {31'b0, if_full_n}, 32'd1);

      // Random stream against a scoreboard. The producer obeys credit; the consumer reads at random.
      sent   = 0;
      budget = 0;
      while ((sent < 200 || sb.size() != 0) && budget < 4000) begin
         wr  = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
         wce = 1'($urandom_range(0, 3) != 0);
         rd  = 1'($urandom_range(0, 1));
         rce = 1'($urandom_range(0, 3) != 0);
         din = $urandom;
         if (rd && rce && if_empty_n) begin
            if (sb.size() == 0) begin
               checkOutput("rand_underflow", {31'b0, if_empty_n}, 32'd0);
            end else begin
               checkOutput("rand_dout", if_dout, sb.pop_front());
            end
         end
         if (wr && wce && if_full_n) begin
            sb.push_back(din);
            sent++;
         end
         applyStimulus(wr, wce, din, rd, rce);
         tick();
         budget++;
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      checkOutput("rand_leftover", sb.size(), 32'd0);
      checkOutput("rand_end_empty_n", {31'b0, if_empty_n}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_relay_station.md
# fifo_relay_station

Pipelined relay between a stream producer and a FWFT consumer, used on long inter-PE links in the pipelined stencil design. Write-side valid/data and the returned full flag each pass through LEVEL register stages so both directions can be floor-planned across regions. A local circular buffer with an almost-full threshold absorbs the round-trip credit latency. Its external ports match the team's FIFO handshake, so it drops in wherever a stream FIFO sits.

## Interface
- DATA_WIDTH, 32, payload width.
- LEVEL, 2, register stages on the forward write path and on the backward full path. Must be ≥1.
- DEPTH, 8, buffer entries. Must be ≥2*LEVEL+2. Any integer value; a power of two is not required.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- if_full_n  out  1  producer may write when high.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  if_dout is valid when high.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read/pop request.
- if_dout  out  DATA_WIDTH  head-of-queue data (FWFT).

## Operation
- Write fire: if_write & if_write_ce & if_full_n.
  - A fired write enters forward stage 1 as {valid=1, data}.
  - A non-fired cycle enters {valid=0}.
  - Writes while if_full_n=0 are dropped. That is producer misuse; it must not corrupt state.
- Forward path: LEVEL stages of valid plus data. Only valid is reset. Data regs are unreset.
- Buffer (relay_buffer):
  - Circular RAM with wr_ptr, rd_ptr and occ.
  - Widths: ptr $clog2(DEPTH); occ $clog2(DEPTH+1).
  - Pointers wrap from DEPTH-1 to 0.
  - The last forward stage with valid=1 writes mem[wr_ptr].
- Read fire: if_read & if_read_ce & (occ≠0).
  - A fire advances rd_ptr.
  - A read while empty is ignored.
- Occupancy update:
  - Arrival and read fire in the same cycle: occ unchanged.
  - Arrival only: occ+1.
  - Read only: occ−1.
- if_empty_n = (occ≠0). if_dout = mem[rd_ptr]. if_dout is undefined while empty.
- Credit:
  - raw_full_n = (occ < DEPTH−2*LEVEL), computed from the registered occ.
  - raw_full_n passes through LEVEL backward regs to drive if_full_n.
  - This guarantees occ ≤ DEPTH with no reads.
- An arrival while occ==DEPTH is a design error. It is checked by a simulation assertion, not handled in logic.
- Reset:
  - Clears occ, both pointers and all forward valids.
  - Sets all backward regs to 1.
  - Words in flight or stored are discarded.

## Timing
- Reset values, from the cycle after reset is sampled: if_full_n=1, if_empty_n=0.
- Forward latency: a write fired in cycle t is visible at if_empty_n/if_dout in cycle t+LEVEL+1.
- Credit latency: an occ change in cycle t affects if_full_n in cycle t+LEVEL.
- Read latency:
  - A read fired in cycle t presents the next word in cycle t+1.
  - Sustained throughput is 1 word/cycle when the consumer reads each cycle.
- No combinational path from any input to any output. Only if_dout/if_empty_n depend combinationally on registered state.
- Reset asserted mid-transfer: the state above holds at cycle+1. Pre-reset words never appear.

## Structure
- Sub-module relay_buffer: circular FWFT buffer with occ and raw_full_n threshold output. Parameters DATA_WIDTH, DEPTH, THRESH=DEPTH−2*LEVEL.
- Top level: forward and backward register chains (generate loop over LEVEL) plus the relay_buffer instance.
- No shared-package typedefs needed. Derived widths are localparams. LEVEL/DEPTH legality is checked by an elaboration-time assertion.

## Test plan
- Reset (LEVEL=2, DEPTH=8) → if_full_n=1, if_empty_n=0. if_read pulses in cycles 1–3 change nothing.
- Single write 0xA5 fired in cycle 10 → if_empty_n=1 with if_dout=0xA5 at cycle 13. Read in cycle 13 → if_empty_n=0 at cycle 14.
- Writes every cycle from cycle 0, no reads, producer obeys if_full_n → if_full_n=0 from cycle 8. Exactly 8 words stored, no assertion. Reading all 8 returns them in order.
- 2000 random words, random if_write_ce/if_read_ce/if_read, LEVEL∈{1,3}, DEPTH∈{2*LEVEL+2, 13} → output order equals input order. occ never exceeds DEPTH.
- Write with if_full_n=0, and write with if_write_ce=0 → word never appears, occ unchanged.
- Reset in the cycle after 5 words are stored and 2 are in flight → if_empty_n=0 next cycle. None of the 7 words ever appears. if_full_n=1.
